// File: rtl/fnd_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: one digit per scan slot,
// active-low font and digit select. Define FND_HEX_EN to render nibbles A..F.
module fnd_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_load,
  input  logic                  i_lzb_en,
  output logic [DIGITS-1:0]     o_fnd_comm,
  output logic [7:0]            o_fnd_font,
  output logic                  o_scan_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow_value;
  logic [DIGITS-1:0]   shadow_dp;
  logic                wrap;

  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                zero_run;
  logic [DIGITS-1:0]   next_comm;
  logic [7:0]          next_font;

  assign wrap = (presc == CNT_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc       <= '0;
      idx         <= '0;
      o_scan_tick <= 1'b0;
    end else begin
      o_scan_tick <= wrap;
      if (wrap) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
    end else if (i_load) begin
      shadow_value <= i_value;
      shadow_dp    <= i_dp;
    end
  end

  // Segment order {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h18;
`ifdef FND_HEX_EN
      4'd10:   seg = 7'h08;
      4'd11:   seg = 7'h03;
      4'd12:   seg = 7'h46;
      4'd13:   seg = 7'h21;
      4'd14:   seg = 7'h06;
      4'd15:   seg = 7'h0e;
`endif
      default: seg = 7'h7f;
    endcase
    return seg;
  endfunction

  // Walk from the most significant digit down; zero_run stays set while every
  // nibble seen so far is zero, which is exactly the leading-zero condition.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cur_nib   = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    zero_run  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (shadow_value[4*k +: 4] == 4'd0);
      if (idx == IDX_W'(k)) begin
        cur_nib   = shadow_value[4*k +: 4];
        cur_dp    = shadow_dp[k];
        cur_blank = i_lzb_en && zero_run && (k != 0);
      end
    end
  end

  assign next_comm = ~(DIGITS'(1) << idx);
  assign next_font = {~cur_dp, cur_blank ? 7'h7f : decode(cur_nib)};

  // Select and font are registered together so they always refer to one digit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_fnd_comm <= '1;
      o_fnd_font <= 8'hff;
    end else begin
      o_fnd_comm <= next_comm;
      o_fnd_font <= next_font;
    end
  end

endmodule

// File: doc/fnd_scan_driver.md
Name: fnd_scan_driver

Overview:
- Time-multiplexed driver for a parametrised bank of common-anode 7-segment (FND) digits.
- Captures a packed BCD value and scans one digit per refresh slot.
- Per digit: decodes the nibble to an active-low font, applies decimal point and leading-zero blanking, and drives the matching active-low digit select.
- Sits between counter/datapath logic and the board FND pins; replaces per-digit combinational decoders.

Parameters:
- DIGITS, 4, number of digits scanned (1..8); digit 0 = least significant, rightmost.
- SCAN_DIV, 100000, clock cycles per digit slot (>=2); 1 kHz slot at 100 MHz.

Ports:
- i_clk  input  1  system clock.
- i_reset_n  input  1  asynchronous active-low reset.
- i_value  input  4*DIGITS  packed BCD; nibble k = digit k.
- i_dp  input  DIGITS  decimal point request per digit, 1 = lit.
- i_load  input  1  capture i_value/i_dp into shadow registers this cycle.
- i_lzb_en  input  1  leading-zero blanking enable.
- o_fnd_comm  output  DIGITS  digit select, active-low one-hot.
- o_fnd_font  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- o_scan_tick  output  1  one-cycle pulse when the digit index advances.

Behaviour:
- Clocking: one clock, i_clk. Reset is asynchronous, active-low on i_reset_n.
- Reset state:
  - prescaler = 0, digit index = 0, shadow value = 0, shadow dp = 0.
  - o_fnd_comm = all ones (all off), o_fnd_font = 8'hff, o_scan_tick = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - o_scan_tick is registered, high for the single cycle following the edge at which the count wraps to 0.
- Digit index:
  - Advances on the same edge as the prescaler wrap, 0..DIGITS-1, wrapping DIGITS-1 -> 0.
  - DIGITS=1: index stays 0; ticks still pulse.
- Shadow capture:
  - On an edge with i_load=1, shadow <= i_value, i_dp.
  - Otherwise the shadow holds.
  - i_load asserted continuously gives live display.
- Outputs:
  - Registered from the current index and shadow, one cycle behind.
  - Load at edge N is visible on o_fnd_font at edge N+1 if the loaded digit is currently selected.
  - Index change at edge N: o_fnd_comm and o_fnd_font switch together at edge N+1. They never disagree on which digit is shown.
- o_fnd_comm: bit[index] = 0, all other bits = 1.
- Font decode, segments [6:0]:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:18.
  - Nibbles 10..15 decode to 7'h7f (blank) unless FND_HEX_EN.
- Decimal point: font bit7 = ~shadow_dp[index].
- Leading-zero blanking (i_lzb_en=1):
  - Digit k>0 is blanked (segments 7'h7f) when its nibble and all more-significant nibbles are 0.
  - Digit 0 is never blanked.
  - The dp bit is still applied on blanked digits.
  - i_lzb_en is sampled combinationally each cycle; no shadow.
- Simultaneous events: i_load together with a tick gives index advance and capture on the same edge; the next outputs use the new shadow.
- Reset mid-scan: all outputs go to reset values immediately (asynchronous). Scanning resumes from digit 0 after release.

Optional Feature:
- Macro: FND_HEX_EN.
- Defined: nibbles 10..15 decode to A:08, b:03, C:46, d:21, E:06, F:0E (segments [6:0], active-low). Leading-zero blanking treats only 0 as zero.
- Undefined: nibbles 10..15 render blank (7'h7f). dp is still applied.

Test Plan:
- Reset: hold i_reset_n=0 mid-scan -> o_fnd_comm=4'b1111, o_fnd_font=8'hff, o_scan_tick=0 without a clock edge. After release, first o_scan_tick occurs SCAN_DIV cycles later.
- Scan order (DIGITS=4, SCAN_DIV=4): load i_value=16'h1234, i_dp=0 -> comm sequence 1110,1101,1011,0111 repeating; fonts f9(4 shown as 99 on digit0: order 99,b0,a4,f9); each slot exactly 4 cycles; tick spaced 4 cycles.
- Leading-zero blanking: i_value=16'h0070, i_lzb_en=1 -> digit0 c0, digit1 f8, digit2 ff, digit3 ff. With i_lzb_en=0 -> digit2 and digit3 show c0.
- Decimal point on blank: i_value=0, i_dp=4'b0100, i_lzb_en=1 -> digit2 font 8'h7f, digit0 8'hc0, digit1 and digit3 8'hff.
- Load timing: i_load pulse changing digit0 from 1 to 9 while digit0 is selected -> o_fnd_font f9 -> 98 exactly one edge after the load edge. Without i_load, an i_value change has no effect.
- Hex mode: i_value nibble 4'hA on digit0 -> 8'h88 with FND_HEX_EN, 8'hff without.
